fetch_ctrl: RTL and testbench

Instruction fetch sequencer for the 4096x32 instruction ROM, which has a 1-cycle synchronous read.
- Holds the fetch PC, drives the ROM word address and tracks the read in flight.
- Hands {pc, inst} to decode over a valid/ready handshake.
- Absorbs decode back-pressure with a 1-entry hold buffer and services branch/jump redirects.
- Sits between the branch unit and the ROM at the front of the pipeline.

---
 rtl/fetch_ctrl_if.sv | 43 ++++
 rtl/fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_fetch_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if : bus bundle between the fetch sequencer, its instruction ROM,
//                 the branch unit (redirects) and decode.
//
// Signals
//   redirect_valid / redirect_pc : redirect request and target byte PC
//   rom_addr / rom_qout          : ROM word address and 1-cycle-late read data
//   out_valid / out_ready        : instruction handshake toward decode
//   out_pc / out_inst            : byte PC and instruction word toward decode
//
// Modports
//   master : the fetch sequencer (drives rom_addr and out_*)
//   slave  : the surroundings (ROM, branch unit, decode)
//
// Handshake: a transfer happens in every cycle where out_valid and out_ready
// are both 1 at the rising clock edge. While out_valid=1 and out_ready=0 the
// master keeps out_pc/out_inst stable. A redirect cancels the offer, so
// out_valid may drop without a transfer in that one case. out_ready may
// depend on nothing but decode's own state.
// ---------------------------------------------------------------------------
interface fetch_ctrl_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
);
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [AWIDTH-1:0] rom_addr;
  logic [DWIDTH-1:0] rom_qout;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [DWIDTH-1:0] out_inst;

  modport master (
    input  redirect_valid, redirect_pc, rom_qout, out_ready,
    output rom_addr, out_valid, out_pc, out_inst
  );

  modport slave (
    output redirect_valid, redirect_pc, rom_qout, out_ready,
    input  rom_addr, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl : instruction fetch sequencer for a ROM with a 1-cycle
//              synchronous read.
//
// It keeps the fetch PC, drives the ROM word address, tracks the read in
// flight and hands {pc, inst} to decode over a valid/ready handshake. A
// 1-entry hold buffer absorbs decode back-pressure so the ROM data of a
// stalled response is not lost. Redirects from the branch unit take priority
// over everything except reset.
//
// Ports
//   clk       : clock, all state updates on its rising edge
//   rst_n     : synchronous active-low reset
//   bus       : fetch_ctrl_if.master (redirect, ROM and decode signals)
//   stall_cnt : (only with FETCH_STALL_CNT_EN) cycles with out_valid=1 and
//               out_ready=0, wraps at 2^32, cleared only by reset
//
// Configuration macro
//   FETCH_STALL_CNT_EN : adds the stall_cnt output and its counter.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int          AWIDTH   = 12,
  parameter int          DWIDTH   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_ctrl_if.master bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  // PCs are word aligned; the two low bits of any supplied PC are dropped.
  localparam logic [31:0] RESET_PC_AL = RESET_PC & ~32'd3;

  logic [31:0]       fetch_pc;
  logic              rsp_valid;
  logic [31:0]       rsp_pc;
  logic              hold_valid;
  logic [31:0]       hold_pc;
  logic [DWIDTH-1:0] hold_inst;

  logic [31:0]       redirect_al;
  logic              issue;

  assign redirect_al = bus.redirect_pc & ~32'd3;

  // The ROM samples the address at the edge, so a redirect target is put on
  // the address in the same cycle the redirect is requested; its data then
  // lines up with rsp_valid in the following cycle. PCs beyond the ROM simply
  // alias because only the word-address bits are forwarded.
  assign bus.rom_addr = bus.redirect_valid ? redirect_al[AWIDTH+1:2]
                                           : fetch_pc[AWIDTH+1:2];

  // A new read is started whenever the current offer is consumed, nothing is
  // being offered, or a redirect throws the current offer away.
  assign issue = bus.redirect_valid | bus.out_ready | ~(hold_valid | rsp_valid);

  // The hold buffer always holds the older instruction, so it wins the mux.
  always_comb begin
    bus.out_pc   = '0;
    bus.out_inst = '0;
    if (hold_valid) begin
      bus.out_pc   = hold_pc;
      bus.out_inst = hold_inst;
    end else if (rsp_valid) begin
      bus.out_pc   = rsp_pc;
      bus.out_inst = bus.rom_qout;
    end
  end

  assign bus.out_valid = (hold_valid | rsp_valid) & ~bus.redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC_AL;
      rsp_valid  <= 1'b0;
      rsp_pc     <= '0;
      hold_valid <= 1'b0;
      hold_pc    <= '0;
      hold_inst  <= '0;
    end else if (bus.redirect_valid) begin
      // The read in flight and any held instruction belong to the wrong path.
      hold_valid <= 1'b0;
      rsp_valid  <= 1'b1;
      rsp_pc     <= redirect_al;
      fetch_pc   <= redirect_al + 32'd4;
    end else begin
      if (hold_valid) begin
        if (bus.out_ready) begin
          hold_valid <= 1'b0;
        end
      end else if (rsp_valid && !bus.out_ready) begin
        // ROM data is only valid for one cycle; park it before it is lost.
        hold_valid <= 1'b1;
        hold_pc    <= rsp_pc;
        hold_inst  <= bus.rom_qout;
      end

      if (issue) begin
        rsp_valid <= 1'b1;
        rsp_pc    <= fetch_pc;
        fetch_pc  <= fetch_pc + 32'd4;
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // A stall moves the response into the hold buffer and suppresses the next
  // read, so both can never be occupied at once.
  hold_rsp_exclusive : assert property (
    @(posedge clk) disable iff (!rst_n) !(hold_valid && rsp_valid)
  );

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (bus.out_valid && !bus.out_ready) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl : self-checking bench for fetch_ctrl.
//
// Reference model: after any non-reset cycle the sequencer always has an
// instruction to offer, so out_valid is 1 in every cycle except the first
// cycle after reset and any redirect cycle. The stream accepted by decode is
// RESET_PC, +4, +8, ... restarted at the aligned target of each redirect.
// The instruction for a PC is ROM word (pc/4) mod 4096. The driver pushes
// each predicted transfer into exp_q; the monitor pops on every real one.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;
  localparam int          AW  = 12;
  localparam int          DW  = 32;
  localparam logic [31:0] RPC = 32'h0000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  fetch_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .RESET_PC(RPC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // ROM: word k holds 0x1000_0000 + k, 1-cycle synchronous read
  logic [DW-1:0] rom_mem [1<<AW];
  initial begin
    for (int k = 0; k < (1 << AW); k++) rom_mem[k] = 32'h1000_0000 + k;
  end
  always @(posedge clk) bus.rom_qout <= rom_mem[bus.rom_addr];

  // scoreboard state
  logic [63:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  // reference model state
  bit          known = 1'b0;
  bit          primed = 1'b0;
  logic [31:0] model_pc = RPC & ~32'd3;
  logic [31:0] model_cnt = '0;

  // per-cycle expectations published to the monitor
  bit          chk_en = 1'b0;
  bit          exp_valid = 1'b0;
  bit          exp_zero = 1'b0;
  logic [31:0] exp_cnt = '0;

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) % (1 << AW));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: one call = one clock cycle of stimulus plus model update
  task automatic drive_cycle(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst_n              = rst;
    bus.out_ready      = rst ? rdy : 1'b0;
    bus.redirect_valid = rst ? rv : 1'b0;
    bus.redirect_pc    = rpc;
    chk_en    = known;
    exp_valid = primed & ~bus.redirect_valid;
    exp_zero  = ~primed;
    exp_cnt   = model_cnt;
    if (!rst) begin
      primed    = 1'b0;
      model_pc  = RPC & ~32'd3;
      model_cnt = '0;
      known     = 1'b1;
    end else begin
      if (exp_valid && !bus.out_ready) model_cnt = model_cnt + 32'd1;
      if (bus.redirect_valid) begin
        model_pc = rpc & ~32'd3;
      end else if (exp_valid && bus.out_ready) begin
        exp_q.push_back({model_pc, rom_word(model_pc)});
        model_pc = model_pc + 32'd4;
      end
      primed = 1'b1;
    end
  endtask

  // monitor
  bit          prev_stall = 1'b0;
  logic [31:0] prev_pc;
  logic [DW-1:0] prev_inst;
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
      if (exp_zero) check("reset_outputs", {bus.out_pc, bus.out_inst}, 64'h0);
`ifdef FETCH_STALL_CNT_EN
      check("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
`endif
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_accept", {bus.out_pc, bus.out_inst}, 64'hx);
        end else begin
          check("accept_pc_inst", {bus.out_pc, bus.out_inst}, exp_q.pop_front());
        end
      end
      if (prev_stall && bus.out_valid)
        check("stall_stable", {bus.out_pc, bus.out_inst}, {prev_pc, prev_inst});
      prev_stall = bus.out_valid && !bus.out_ready && rst_n;
      prev_pc    = bus.out_pc;
      prev_inst  = bus.out_inst;
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // stimulus
  initial begin
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // reset, then streaming with decode always ready: 0x0, 0x4
    drive_cycle(0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0);
    drive_cycle(1, 1, 0, 0);
    drive_cycle(1, 1, 0, 0);
    // 0x8 stalled for three cycles, then 0x8 and 0xC accepted
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 1, 0, 0);
    drive_cycle(1, 1, 0, 0);
    // redirect to 0x200 while 0x10 is offered
    drive_cycle(1, 1, 1, 32'h200);
    for (int i = 0; i < 3; i++) drive_cycle(1, 1, 0, 0);
    // hold buffer occupied, then redirect to the top of the ROM
    drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 0, 1, 32'h3FFC);
    for (int i = 0; i < 3; i++) drive_cycle(1, 1, 0, 0);
    // misaligned redirect
    drive_cycle(1, 1, 1, 32'h103);
    drive_cycle(1, 1, 0, 0);
    drive_cycle(1, 1, 0, 0);
    // stall into the hold buffer, then a one-cycle reset mid-stream
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, 0);
    drive_cycle(0, 1, 1, 32'h800);
    for (int i = 0; i < 4; i++) drive_cycle(1, 1, 0, 0);
    // back-to-back redirects: only the last target is delivered
    drive_cycle(1, 1, 1, 32'h400);
    drive_cycle(1, 1, 1, 32'h600);
    drive_cycle(1, 1, 0, 0);
    drive_cycle(1, 1, 0, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit          r_rst;
      bit          r_rdy;
      bit          r_rv;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 99) >= 2);
      r_rdy = ($urandom_range(0, 9) < 7);
      r_rv  = ($urandom_range(0, 9) == 0);
      r_pc  = ($urandom_range(0, 3) == 0) ? (32'h3FF0 + 32'($urandom_range(0, 15)))
                                          : $urandom;
      drive_cycle(r_rst, r_rdy, r_rv, r_pc);
    end
    drive_cycle(1, 1, 0, 0);
    @(posedge clk);
    #1;
    chk_en = 1'b0;

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
